wb2ahb_bridge: RTL and testbench

Parametrised Wishbone-slave to AHB-master bridge for a single, clock-aligned bus domain. It accepts classic single Wishbone read and write cycles and converts each into one fully pipelined AHB SINGLE transfer: an address phase followed by a data phase. Byte lanes map to a narrow `hsize` with aligned `haddr`. AHB ERROR is returned as a Wishbone `err_o`, and RETRY/SPLIT responses are handled as described under Configuration. It connects a Wishbone master directly to an AHB-Lite-style slave; there is no arbitration.

---
 rtl/wb2ahb_pkg.sv | 22 ++
 rtl/wb2ahb_sel_decode.sv | 24 ++
 rtl/wb2ahb_bridge.sv | 119 +++++++++++
 tb/tb_wb2ahb_bridge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb2ahb_pkg.sv
// wb2ahb_pkg: AHB encodings, FSM state type and byte-lane decode result shared by the bridge
package wb2ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HSIZE_DWORD   = 3'b011;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;
   localparam logic [1:0] HRESP_RETRY   = 2'b10;
   localparam logic [1:0] HRESP_SPLIT   = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_TERM} state_t;

   typedef struct packed {
      logic [2:0] size;
      logic [2:0] low;
      logic       legal;
   } sel_dec_t;
endpackage

// File: rtl/wb2ahb_sel_decode.sv
// wb2ahb_sel_decode: maps a Wishbone byte-select pattern to an aligned AHB size and low address bits
module wb2ahb_sel_decode
   import wb2ahb_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [DWIDTH/8-1:0] sel,
   output sel_dec_t            dec
);
   localparam int NB  = DWIDTH / 8;
   localparam int LNB = $clog2(NB);

   function automatic logic [NB-1:0] lane_mask(input int s, input int k);
      for (int b = 0; b < NB; b++) lane_mask[b] = (b >= k) && (b < k + (1 << s));
   endfunction

   // a pattern is legal only if it is a contiguous, naturally aligned power-of-two run of lanes
   always_comb begin
      dec = '0;
      for (int s = 0; s <= LNB; s++)
         for (int k = 0; k < NB; k += 1 << s)
            if (sel == lane_mask(s, k)) dec = '{size: 3'(s), low: 3'(k), legal: 1'b1};
   end
endmodule

// File: rtl/wb2ahb_bridge.sv
// wb2ahb_bridge: Wishbone classic slave to AHB SINGLE-transfer master; WB2AHB_RETRY_EN enables RETRY/SPLIT re-issue
module wb2ahb_bridge
   import wb2ahb_pkg::*;
#(
   parameter int AWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int MAX_RETRY = 4
) (
   input  logic                hclk,
   input  logic                hresetn,
   input  logic [AWIDTH-1:0]   addr_i,
   input  logic [DWIDTH-1:0]   data_i,
   input  logic [DWIDTH/8-1:0] sel_i,
   input  logic                we_i,
   input  logic                cyc_i,
   input  logic                stb_i,
   output logic [DWIDTH-1:0]   data_o,
   output logic                ack_o,
   output logic                err_o,
   output logic [AWIDTH-1:0]   haddr,
   output logic [1:0]          htrans,
   output logic                hwrite,
   output logic [2:0]          hsize,
   output logic [2:0]          hburst,
   output logic [DWIDTH-1:0]   hwdata,
   input  logic [DWIDTH-1:0]   hrdata,
   input  logic                hready,
   input  logic [1:0]          hresp
);
   localparam int         NB       = DWIDTH / 8;
   localparam logic [2:0] SIZE_RST = (DWIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;

   state_t   state, state_n;
   sel_dec_t dec;
   logic     req, live, legal_q, drop_q, fire_ok, fire_err;
`ifdef WB2AHB_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic          reissue;
   logic [RW-1:0] retry_cnt;
`endif

   wb2ahb_sel_decode #(.DWIDTH(DWIDTH)) u_dec (.sel(sel_i), .dec(dec));

   assign req    = cyc_i & stb_i;
   assign live   = cyc_i & ~drop_q;
   assign hburst = HBURST_SINGLE;

   // state register
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state <= ST_IDLE;
      else          state <= state_n;
   end

   // next state and termination decision; an illegal request idles one cycle in ADDR with htrans IDLE so err lands two cycles after the strobe
   always_comb begin
      state_n  = state;
      fire_ok  = 1'b0;
      fire_err = 1'b0;
`ifdef WB2AHB_RETRY_EN
      reissue  = 1'b0;
`endif
      case (state)
         ST_IDLE: state_n = req ? ST_ADDR : ST_IDLE;
         ST_ADDR: begin
            fire_err = ~legal_q;
            state_n  = ~legal_q ? ST_TERM : hready ? ST_DATA : ST_ADDR;
         end
         ST_DATA: if (hready) begin
            fire_ok  = hresp == HRESP_OKAY;
`ifdef WB2AHB_RETRY_EN
            reissue  = hresp[1] && retry_cnt < RW'(MAX_RETRY);
            fire_err = ~fire_ok & ~reissue;
            state_n  = reissue ? ST_ADDR : ST_TERM;
`else
            fire_err = ~fire_ok;
            state_n  = ST_TERM;
`endif
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // registered AHB and Wishbone outputs plus request capture; a dropped cycle still completes on AHB but is never terminated
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         htrans  <= HTRANS_IDLE;
         haddr   <= '0;
         hwrite  <= 1'b0;
         hsize   <= SIZE_RST;
         hwdata  <= '0;
         data_o  <= '0;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         legal_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         ack_o  <= fire_ok & live;
         err_o  <= fire_err & live;
         drop_q <= (state != ST_IDLE) && (drop_q | ~cyc_i);
         htrans <= (state_n == ST_ADDR && (state != ST_IDLE || dec.legal)) ? HTRANS_NONSEQ : HTRANS_IDLE;
         if (state == ST_IDLE && req) begin
            legal_q <= dec.legal;
            haddr   <= (addr_i & ~AWIDTH'(NB - 1)) | AWIDTH'(dec.low);
            hwrite  <= we_i;
            hsize   <= dec.size;
            hwdata  <= we_i ? data_i : hwdata;
         end
         if (state == ST_DATA && hready && hresp == HRESP_OKAY && !hwrite) data_o <= hrdata;
      end
   end

`ifdef WB2AHB_RETRY_EN
   // retry count, cleared whenever the bridge is idle
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) retry_cnt <= '0;
      else          retry_cnt <= (state == ST_IDLE) ? '0 : retry_cnt + RW'(reissue);
   end
`endif
endmodule

// File: tb/tb_wb2ahb_bridge.sv
// tb_wb2ahb_bridge: directed self-checking bench for wb2ahb_bridge (DWIDTH=32)
module tb_wb2ahb_bridge;
   logic        hclk = 1'b0;
   logic        hresetn;
   logic [31:0] addr_i, data_i, data_o, haddr, hwdata, hrdata;
   logic [3:0]  sel_i;
   logic        we_i, cyc_i, stb_i, ack_o, err_o, hwrite, hready;
   logic [1:0]  htrans, hresp;
   logic [2:0]  hsize, hburst;
   int          tests = 0;
   int          fails = 0;

   wb2ahb_bridge #(.AWIDTH(32), .DWIDTH(32), .MAX_RETRY(4)) dut (
      .hclk(hclk), .hresetn(hresetn), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
      .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .data_o(data_o), .ack_o(ack_o), .err_o(err_o),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
      .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
   );

   always #5 hclk = ~hclk;

   task automatic tick;
      @(posedge hclk);
      #1;
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
      addr_i = a;
      data_i = d;
      sel_i  = s;
      we_i   = w;
      cyc_i  = 1'b1;
      stb_i  = 1'b1;
      tick();
   endtask

   task automatic release_bus;
      cyc_i = 1'b0;
      stb_i = 1'b0;
   endtask

   task automatic test_reset;
      tests++; if (htrans !== 2'b00) begin fails++; $display("FAIL rst_htrans: got %b want 00", htrans); end
      tests++; if (haddr !== 32'h0) begin fails++; $display("FAIL rst_haddr: got %h want 0", haddr); end
      tests++; if (hwrite !== 1'b0) begin fails++; $display("FAIL rst_hwrite: got %b want 0", hwrite); end
      tests++; if (hsize !== 3'b010) begin fails++; $display("FAIL rst_hsize: got %b want 010", hsize); end
      tests++; if (hburst !== 3'b000) begin fails++; $display("FAIL rst_hburst: got %b want 000", hburst); end
      tests++; if (hwdata !== 32'h0) begin fails++; $display("FAIL rst_hwdata: got %h want 0", hwdata); end
      tests++; if (data_o !== 32'h0) begin fails++; $display("FAIL rst_data_o: got %h want 0", data_o); end
      tests++; if ({ack_o, err_o} !== 2'b00) begin fails++; $display("FAIL rst_ack_err: got %b want 00", {ack_o, err_o}); end
   endtask

   task automatic test_word_write;
      launch(32'h100, 32'hDEADBEEF, 4'hF, 1'b1);
      tests++; if (htrans !== 2'b10) begin fails++; $display("FAIL ww_htrans_c1: got %b want 10", htrans); end
      tests++; if (haddr !== 32'h100) begin fails++; $display("FAIL ww_haddr: got %h want 100", haddr); end
      tests++; if ({hwrite, hsize} !== 4'b1010) begin fails++; $display("FAIL ww_hwrite_hsize: got %b want 1010", {hwrite, hsize}); end
      tick();
      tests++; if (htrans !== 2'b00) begin fails++; $display("FAIL ww_htrans_c2: got %b want 00", htrans); end
      tests++; if (hwdata !== 32'hDEADBEEF) begin fails++; $display("FAIL ww_hwdata: got %h want deadbeef", hwdata); end
      tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL ww_ack_c2: got %b want 0", ack_o); end
      tick();
      tests++; if ({ack_o, err_o} !== 2'b10) begin fails++; $display("FAIL ww_ack_c3: got %b want 10", {ack_o, err_o}); end
      release_bus();
      tick();
      tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL ww_ack_c4: got %b want 0", ack_o); end
      tick();
   endtask

   task automatic test_byte_read_wait;
      hrdata = 32'h5A000000;
      launch(32'h203, 32'h0, 4'b1000, 1'b0);
      tests++; if ({htrans, haddr} !== {2'b10, 32'h203}) begin fails++; $display("FAIL br_addr_phase: got %b %h want 10 203", htrans, haddr); end
      tests++; if ({hwrite, hsize} !== 4'b0000) begin fails++; $display("FAIL br_hwrite_hsize: got %b want 0000", {hwrite, hsize}); end
      tick();
      hready = 1'b0;
      tick();
      tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL br_ack_c3: got %b want 0", ack_o); end
      tick();
      hready = 1'b1;
      tests++; if (ack_o !== 1'b0) begin fails++; $display("FAIL br_ack_c4: got %b want 0", ack_o); end
      tick();
      tests++; if (ack_o !== 1'b1) begin fails++; $display("FAIL br_ack_c5: got %b want 1", ack_o); end
      tests++; if (data_o !== 32'h5A000000) begin fails++; $display("FAIL br_data_o: got %h want 5a000000", data_o); end
      release_bus();
      tick();
   endtask

   task automatic test_halfword_read;
      hrdata = 32'hABCD0000;
      launch(32'h10, 32'h0, 4'b1100, 1'b0);
      tests++; if ({haddr, hsize} !== {32'h12, 3'b001}) begin fails++; $display("FAIL hw_addr_size: got %h %b want 12 001", haddr, hsize); end
      tick();
      tick();
      tests++; if ({ack_o, data_o} !== {1'b1, 32'hABCD0000}) begin fails++; $display("FAIL hw_ack_data: got %b %h want 1 abcd0000", ack_o, data_o); end
      release_bus();
      tick();
   endtask

   task automatic test_error;
      launch(32'h80, 32'h1234, 4'hF, 1'b1);
      tick();
      hready = 1'b0;
      hresp  = 2'b01;
      tick();
      hready = 1'b1;
      tests++; if ({ack_o, err_o} !== 2'b00) begin fails++; $display("FAIL er_c3: got %b want 00", {ack_o, err_o}); end
      tick();
      tests++; if ({ack_o, err_o} !== 2'b01) begin fails++; $display("FAIL er_c4: got %b want 01", {ack_o, err_o}); end
      release_bus();
      hresp = 2'b00;
      tick();
      tests++; if ({ack_o, err_o} !== 2'b00) begin fails++; $display("FAIL er_c5: got %b want 00", {ack_o, err_o}); end
      tick();
   endtask

   task automatic test_illegal_sel;
      launch(32'h40, 32'h0, 4'b0101, 1'b1);
      tests++; if ({htrans, err_o} !== 3'b000) begin fails++; $display("FAIL il_c1: got %b %b want 00 0", htrans, err_o); end
      tick();
      tests++; if ({htrans, err_o, ack_o} !== 4'b0010) begin fails++; $display("FAIL il_c2: got %b %b %b want 00 1 0", htrans, err_o, ack_o); end
      release_bus();
      tick();
      tests++; if ({htrans, err_o} !== 3'b000) begin fails++; $display("FAIL il_c3: got %b %b want 00 0", htrans, err_o); end
      tick();
   endtask

   task automatic test_cyc_drop;
      launch(32'h8, 32'h11, 4'hF, 1'b1);
      release_bus();
      tick();
      tests++; if ({htrans, hwdata} !== {2'b00, 32'h11}) begin fails++; $display("FAIL cd_data_phase: got %b %h want 00 11", htrans, hwdata); end
      tick();
      tests++; if ({ack_o, err_o} !== 2'b00) begin fails++; $display("FAIL cd_term: got %b want 00", {ack_o, err_o}); end
      tick();
   endtask

   task automatic test_retry(input int nretry, input int exp_issues, input logic exp_ack);
      int   issues = 0;
      logic done   = 1'b0;
      hrdata = 32'h77;
      launch(32'h400, 32'h0, 4'hF, 1'b0);
      for (int c = 0; c < 40 && !done; c++) begin
         if (htrans === 2'b10) issues++;
         hresp = (issues <= nretry) ? 2'b10 : 2'b00;
         if (ack_o || err_o) done = 1'b1;
         else tick();
      end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL rt_timeout: got no termination want one within 40 cycles"); end
      tests++; if (issues != exp_issues) begin fails++; $display("FAIL rt_issues: got %0d want %0d", issues, exp_issues); end
      tests++; if ({ack_o, err_o} !== {exp_ack, ~exp_ack}) begin fails++; $display("FAIL rt_term: got %b want %b", {ack_o, err_o}, {exp_ack, ~exp_ack}); end
      release_bus();
      hresp = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_reset_mid;
      launch(32'h300, 32'hCAFEF00D, 4'hF, 1'b1);
      tick();
      tests++; if (hwdata !== 32'hCAFEF00D) begin fails++; $display("FAIL rm_hwdata: got %h want cafef00d", hwdata); end
      hresetn = 1'b0;
      #1;
      tests++; if ({htrans, haddr, hwrite, hsize} !== {2'b00, 32'h0, 1'b0, 3'b010}) begin fails++; $display("FAIL rm_addr_ctl: got %b %h %b %b want 00 0 0 010", htrans, haddr, hwrite, hsize); end
      tests++; if ({hwdata, data_o, ack_o, err_o} !== {64'h0, 2'b00}) begin fails++; $display("FAIL rm_data: got %h %h %b %b want 0 0 0 0", hwdata, data_o, ack_o, err_o); end
      release_bus();
      tick();
      hresetn = 1'b1;
      tick();
      hrdata = 32'h12345678;
      launch(32'h44, 32'h0, 4'hF, 1'b0);
      tests++; if ({htrans, haddr} !== {2'b10, 32'h44}) begin fails++; $display("FAIL rm_relaunch: got %b %h want 10 44", htrans, haddr); end
      tick();
      tick();
      tests++; if ({ack_o, data_o} !== {1'b1, 32'h12345678}) begin fails++; $display("FAIL rm_read: got %b %h want 1 12345678", ack_o, data_o); end
      release_bus();
      tick();
   endtask

   initial begin
      hresetn = 1'b0;
      addr_i  = '0;
      data_i  = '0;
      sel_i   = '0;
      we_i    = 1'b0;
      cyc_i   = 1'b0;
      stb_i   = 1'b0;
      hrdata  = '0;
      hready  = 1'b1;
      hresp   = 2'b00;
      tick();
      test_reset();
      hresetn = 1'b1;
      tick();
      test_word_write();
      test_byte_read_wait();
      test_halfword_read();
      test_error();
      test_illegal_sel();
      test_cyc_drop();
`ifdef WB2AHB_RETRY_EN
      test_retry(2, 3, 1'b1);
      test_retry(5, 5, 1'b0);
`else
      test_retry(2, 1, 1'b0);
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
